// File: rtl/apb_fsm_controller.sv
// Purpose : AHB-to-APB bridge sequencer. Turns each accepted AHB transfer into an
//           APB SETUP/ACCESS pair. Supports back-to-back and pipelined writes.
// Latency : read psel 1 hclk after valid seen in IDLE; write psel 2 hclk (data-phase wait).
// Backpressure: hready_out is driven low for exactly the APB SETUP cycle; all outputs registered.
//
// Ports:
//   hclk, hresetn      clock, synchronous active-low reset
//   valid              current AHB address phase is a bridge transfer
//   hwrite, hwrite_1   write flag now / one hclk ago
//   haddr, haddr_1     AHB address now / one hclk ago
//   hwdata             AHB write data (data phase of the previous address)
//   temp_sel           region code of haddr (001/010/011, 000 = none)
//   paddr, pwdata      APB address / write data
//   pwrite, penable    APB direction / ACCESS-phase strobe
//   psel               one-hot APB slave selects
//   hready_out         AHB ready back to the master (0 = stall)

module apb_fsm_controller #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              valid,
  input  logic              hwrite,
  input  logic              hwrite_1,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [ADDR_W-1:0] haddr_1,
  input  logic [DATA_W-1:0] hwdata,
  input  logic [2:0]        temp_sel,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic              pwrite,
  output logic              penable,
  output logic [2:0]        psel,
  output logic              hready_out
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WWAIT    = 3'd1,
    READ     = 3'd2,
    WRITE    = 3'd3,
    WRITEP   = 3'd4,
    RENABLE  = 3'd5,
    WENABLE  = 3'd6,
    WENABLEP = 3'd7
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        sel_1_q;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              pwrite_q, pwrite_d;
  logic              penable_q, penable_d;
  logic [2:0]        psel_q, psel_d;
  logic              hready_q, hready_d;

  // Output actions chosen by the state decode below.
  logic do_rd_setup;
  logic do_wr_setup;
  logic do_access;
  logic do_quiet;

  // Region code to one-hot slave select; 000 (and unused codes) strobe nothing.
  function automatic logic [2:0] sel_decode(input logic [2:0] code);
    logic [2:0] onehot;
    case (code)
      3'b001:  onehot = 3'b001;
      3'b010:  onehot = 3'b010;
      3'b011:  onehot = 3'b100;
      default: onehot = 3'b000;
    endcase
    return onehot;
  endfunction

  // Next-state and action decode.
  always_comb begin
    state_d     = state_q;
    do_rd_setup = 1'b0;
    do_wr_setup = 1'b0;
    do_access   = 1'b0;
    do_quiet    = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid && !hwrite) begin
          state_d     = READ;
          do_rd_setup = 1'b1;
        end else begin
          // A write address must wait one cycle for its data phase.
          if (valid) state_d = WWAIT;
          do_quiet = 1'b1;
        end
      end
      WWAIT: begin
        // A new transfer arriving with the data marks the pair as pipelined.
        state_d     = valid ? WRITEP : WRITE;
        do_wr_setup = 1'b1;
      end
      READ: begin
        state_d   = RENABLE;
        do_access = 1'b1;
      end
      WRITE: begin
        state_d   = valid ? WENABLEP : WENABLE;
        do_access = 1'b1;
      end
      WRITEP: begin
        state_d   = WENABLEP;
        do_access = 1'b1;
      end
      RENABLE, WENABLE: begin
        if (!valid) begin
          state_d  = IDLE;
          do_quiet = 1'b1;
        end else if (!hwrite) begin
          state_d     = READ;
          do_rd_setup = 1'b1;
        end else begin
          state_d  = WWAIT;
          do_quiet = 1'b1;
        end
      end
      WENABLEP: begin
        // The pipelined transfer was captured a cycle ago, so its direction
        // comes from hwrite_1; its write data is on hwdata right now.
        if (!hwrite_1) begin
          state_d     = READ;
          do_rd_setup = 1'b1;
        end else begin
          state_d     = valid ? WRITEP : WRITE;
          do_wr_setup = 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        do_quiet = 1'b1;
      end
    endcase
  end

  // Registered APB outputs: hold unless an action updates them.
  always_comb begin
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pwrite_d  = pwrite_q;
    penable_d = penable_q;
    psel_d    = psel_q;
    hready_d  = hready_q;
    if (do_rd_setup) begin
      paddr_d   = haddr;
      psel_d    = sel_decode(temp_sel);
      pwrite_d  = 1'b0;
      penable_d = 1'b0;
      hready_d  = 1'b0;
    end
    if (do_wr_setup) begin
      // Address and region are one cycle old; data is the current data phase.
      paddr_d   = haddr_1;
      pwdata_d  = hwdata;
      psel_d    = sel_decode(sel_1_q);
      pwrite_d  = 1'b1;
      penable_d = 1'b0;
      hready_d  = 1'b0;
    end
    if (do_access) begin
      penable_d = 1'b1;
      hready_d  = 1'b1;
    end
    if (do_quiet) begin
      penable_d = 1'b0;
      psel_d    = 3'b000;
      hready_d  = 1'b1;
    end
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state_q   <= IDLE;
      sel_1_q   <= 3'b000;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      penable_q <= 1'b0;
      psel_q    <= 3'b000;
      hready_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      sel_1_q   <= temp_sel;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      penable_q <= penable_d;
      psel_q    <= psel_d;
      hready_q  <= hready_d;
    end
  end

  assign paddr      = paddr_q;
  assign pwdata     = pwdata_q;
  assign pwrite     = pwrite_q;
  assign penable    = penable_q;
  assign psel       = psel_q;
  assign hready_out = hready_q;

  // APB protocol invariants.
  a_psel_onehot: assert property (@(posedge hclk) disable iff (!hresetn)
    $onehot0(psel));
  a_access_single: assert property (@(posedge hclk) disable iff (!hresetn)
    penable |=> !penable);
  a_access_stable: assert property (@(posedge hclk) disable iff (!hresetn)
    penable |-> ($stable(paddr) && $stable(psel) && $stable(pwrite)));

endmodule

// File: doc/apb_fsm_controller.md
Name: apb_fsm_controller

Overview:
- Bridge sequencing FSM. Sits between the AHB slave interface (decoded `valid`, pipelined address/data/write and region select) and the APB bus.
- Converts each accepted AHB transfer into an APB SETUP→ACCESS pair. Supports back-to-back and pipelined writes.
- Stalls the AHB master through `hready_out` while an APB transfer is in SETUP.
- All APB outputs are registered.

Parameters:
- ADDR_W, 32, width of AHB/APB address buses
- DATA_W, 32, width of write data buses

Ports:
- hclk  in  1  single system clock, all logic on rising edge
- hresetn  in  1  reset; one clock; reset is synchronous and active-low
- valid  in  1  current AHB address phase is an accepted bridge transfer
- hwrite  in  1  write flag of current address phase
- hwrite_1  in  1  hwrite delayed one hclk
- haddr  in  ADDR_W  current AHB address
- haddr_1  in  ADDR_W  haddr delayed one hclk
- hwdata  in  DATA_W  current AHB write data (data phase of previous address)
- temp_sel  in  3  region code of current haddr: 001/010/011; 000 = none
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- pwrite  out  1  APB direction
- penable  out  1  APB enable (ACCESS phase)
- psel  out  3  APB slave selects, one-hot
- hready_out  out  1  to AHB master; 0 = stall

Behaviour:
- **Reset** (`hresetn`=0 at edge): state=IDLE, paddr=0, pwdata=0, pwrite=0, penable=0, psel=0, hready_out=1, sel_1=0. Applies mid-transfer too: any in-flight APB cycle is abandoned, no further psel.
- **sel_1**: internal register, loads temp_sel every non-reset cycle. It pairs with haddr_1.
- **psel decode**: 001→001, 010→010, 011→100, 000→000. Source is temp_sel for read setups and sel_1 for write setups.
- **States**: IDLE, WWAIT, READ, WRITE, WRITEP, RENABLE, WENABLE, WENABLEP (3-bit encoding).
- **IDLE**:
  - valid&~hwrite → READ: read setup.
  - valid&hwrite → WWAIT: hready_out=1, psel=0.
  - otherwise stay IDLE, hready_out=1.
- **WWAIT** (waiting for write data): both exits drive write setup.
  - ~valid → WRITE.
  - valid → WRITEP.
- **READ** → RENABLE: penable=1, hready_out=1; other outputs held.
- **WRITE**:
  - ~valid → WENABLE.
  - valid → WENABLEP.
  - Both: penable=1, hready_out=1.
- **WRITEP** → WENABLEP: penable=1, hready_out=1.
- **RENABLE / WENABLE**:
  - ~valid → IDLE.
  - valid&~hwrite → READ: read setup.
  - valid&hwrite → WWAIT.
  - IDLE and WWAIT exits: penable=0, psel=0, hready_out=1.
- **WENABLEP**:
  - hwrite_1&~valid → WRITE: write setup.
  - hwrite_1&valid → WRITEP: write setup.
  - ~hwrite_1 → READ: read setup using haddr.
- **Read setup** (registered): paddr=haddr, psel=dec(temp_sel), pwrite=0, penable=0, hready_out=0.
- **Write setup** (registered): paddr=haddr_1, pwdata=hwdata, psel=dec(sel_1), pwrite=1, penable=0, hready_out=0.
- **Timing**:
  - Each APB transfer is exactly 2 hclk: SETUP with penable=0, then ACCESS with penable=1. No pready; APB slaves are zero-wait.
  - Read: psel asserts 1 cycle after valid sampled in IDLE.
  - Write: psel asserts 2 cycles after valid sampled in IDLE, because of the WWAIT data-phase wait.
- **Holds**: pwdata keeps its last write value during reads. paddr/psel/pwrite are stable between SETUP and ACCESS.
- **Boundaries**:
  - valid with temp_sel=000 still sequences, with psel=000 (no slave strobed).
  - Simultaneous reset and valid: reset wins.

Test Plan:
1. **Reset**: hresetn=0 for 2 cycles with valid=1 → all outputs 0 except hready_out=1; state IDLE after release.
2. **Single read**: valid=1, hwrite=0, haddr=32'h8000_0010, temp_sel=001 for 1 cycle, then idle → next cycle paddr=8000_0010, psel=001, penable=0, hready_out=0; following cycle penable=1, hready_out=1; then psel=0.
3. **Single write**: valid=1, hwrite=1, haddr=32'h8400_0020, temp_sel=010; next cycle hwdata=32'hDEAD_BEEF, valid=0 → psel=010, pwrite=1, paddr=8400_0020, pwdata=DEADBEEF, penable=0; next cycle penable=1; then IDLE.
4. **Back-to-back writes**: addresses 8800_0000, 8800_0004, 8800_0008 with data 1, 2, 3 → three SETUP/ACCESS pairs, psel=100, pwdata 1, 2, 3 in order; hready_out low only in each SETUP cycle.
5. **Write then read**: write 8000_0000 (data 5), then read 8400_0004 → WENABLEP→READ path; read SETUP shows paddr=8400_0004, pwrite=0, psel=010; pwdata stays 5.
6. **Reset mid-transfer**: hresetn=0 during a WRITE SETUP cycle → next cycle psel=0, penable=0, pwrite=0, hready_out=1; no ACCESS cycle occurs.
